// File: rtl/afp3_arb_pkg.sv
// Shared widths, error-bit positions and opcodes for the misc-command arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package afp3_arb_pkg;

    localparam int OPCODE_W = 8;
    localparam int ACTAG_W  = 12;
    localparam int AFUTAG_W = 16;
    localparam int BDF_W    = 16;

    // Sticky error vector layout
    localparam int ERR_W         = 3;
    localparam int ERR_DBL_REQ   = 0;   // request while already pending
    localparam int ERR_CRED_OVF  = 1;   // credit return at full count
    localparam int ERR_CMD_PROTO = 2;   // cmd_valid / grant mismatch

    localparam logic [OPCODE_W-1:0] ASSIGN_ACTAG = 8'h50;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ACTAG_W-1:0]  actag;
        logic [AFUTAG_W-1:0] afutag;
        logic [BDF_W-1:0]    bdf;
    } cmd_t;

endpackage

// File: rtl/afp3_arb_misc_cmd_if.sv
// Bundle of engine request/grant/command lanes and the AFU->TLX command bus.
// Latency: n/a (wiring only).
// Backpressure: none on the wires; flow is governed by TLX command credits.
// Modports: master = arbiter side, slave = engines + TLX side.
interface afp3_arb_misc_cmd_if #(
    parameter int NUM_ENG  = 4,
    parameter int CREDIT_W = 4
);
    import afp3_arb_pkg::*;

    logic [NUM_ENG-1:0]          eng_misc_req;
    logic [NUM_ENG-1:0]          arb_eng_misc_gnt;
    logic [NUM_ENG-1:0]          eng_cmd_valid;
    logic [OPCODE_W*NUM_ENG-1:0] eng_cmd_opcode;
    logic [ACTAG_W*NUM_ENG-1:0]  eng_cmd_actag;
    logic [AFUTAG_W*NUM_ENG-1:0] eng_cmd_afutag;
    logic [BDF_W*NUM_ENG-1:0]    eng_cmd_bdf;
    logic                        tlx_afu_cmd_credit;
    logic                        afu_tlx_cmd_valid;
    logic [OPCODE_W-1:0]         afu_tlx_cmd_opcode;
    logic [ACTAG_W-1:0]          afu_tlx_cmd_actag;
    logic [AFUTAG_W-1:0]         afu_tlx_cmd_afutag;
    logic [BDF_W-1:0]            afu_tlx_cmd_bdf;
    logic [CREDIT_W-1:0]         arb_credit_cnt;
    logic [ERR_W-1:0]            arb_misc_error;

    modport master (
        input  eng_misc_req, eng_cmd_valid, eng_cmd_opcode, eng_cmd_actag,
               eng_cmd_afutag, eng_cmd_bdf, tlx_afu_cmd_credit,
        output arb_eng_misc_gnt, afu_tlx_cmd_valid, afu_tlx_cmd_opcode,
               afu_tlx_cmd_actag, afu_tlx_cmd_afutag, afu_tlx_cmd_bdf,
               arb_credit_cnt, arb_misc_error
    );

    modport slave (
        output eng_misc_req, eng_cmd_valid, eng_cmd_opcode, eng_cmd_actag,
               eng_cmd_afutag, eng_cmd_bdf, tlx_afu_cmd_credit,
        input  arb_eng_misc_gnt, afu_tlx_cmd_valid, afu_tlx_cmd_opcode,
               afu_tlx_cmd_actag, afu_tlx_cmd_afutag, afu_tlx_cmd_bdf,
               arb_credit_cnt, arb_misc_error
    );

endinterface

// File: rtl/afp3_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; caller gates the result.
// Ports: req (request vector), ptr (last winner), pick (one-hot), idx, any.
module afp3_rr_pick #(
    parameter int NUM_ENG = 4
) (
    input  logic [NUM_ENG-1:0]         req,
    input  logic [$clog2(NUM_ENG)-1:0] ptr,
    output logic [NUM_ENG-1:0]         pick,
    output logic [$clog2(NUM_ENG)-1:0] idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_ENG);

    logic [IDX_W-1:0] cand;

    // k runs 1..NUM_ENG so the previous winner is examined last.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= NUM_ENG; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_ENG);
            if (!any && req[cand]) begin
                any        = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/afp3_arb_misc_cmd.sv
// Misc-command arbiter: one-hot credit-gated grants to engines, registered TLX command bus.
// Latency: request pulse t -> grant t+2 -> afu_tlx_cmd_valid t+3.
// Backpressure: zero TLX credits hold all requests pending; no grants issue until a credit returns.
// Ports: clock, reset_n (async active-low), bus (afp3_arb_misc_cmd_if.master).
// Build option AFP3_ARB_MISC_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module afp3_arb_misc_cmd
    import afp3_arb_pkg::*;
#(
    parameter int NUM_ENG      = 4,
    parameter int CREDIT_W     = 4,
    parameter int INIT_CREDITS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    afp3_arb_misc_cmd_if.master bus
);
    localparam int                  IDX_W    = $clog2(NUM_ENG);
    localparam logic [CREDIT_W-1:0] CRED_RST = CREDIT_W'(INIT_CREDITS);

    logic [NUM_ENG-1:0]  pending_q, pending_d;
    logic [NUM_ENG-1:0]  gnt_q, gnt_d;
    logic [NUM_ENG-1:0]  pick;
    logic                pick_any;
    logic                gnt_any;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                cred_ovf;
    logic                dbl_req;
    logic                proto_err;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [NUM_ENG-1:0]  cap_sel;
    logic                cmd_vld_q, cmd_vld_d;
    cmd_t                cmd_q, cmd_d;

    // ---------------- Winner selection ----------------
`ifdef AFP3_ARB_MISC_FIXED_PRI_EN
    always_comb begin
        pick     = '0;
        pick_any = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (!pick_any && pending_q[i]) begin
                pick[i]  = 1'b1;
                pick_any = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] pick_idx;

    afp3_rr_pick #(.NUM_ENG(NUM_ENG)) u_rr_pick (
        .req  (pending_q),
        .ptr  (rr_ptr_q),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Reset to the top lane so lane 0 is favoured first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= IDX_W'(NUM_ENG - 1);
        end else if (gnt_any) begin
            rr_ptr_q <= pick_idx;
        end
    end
`endif

    // A grant consumes a credit, so no grant can issue at zero.
    assign gnt_any = pick_any && (credit_q != '0);
    assign gnt_d   = gnt_any ? pick : '0;

    // A request arriving with the grant re-arms the lane rather than being lost.
    assign pending_d = (pending_q & ~gnt_d) | bus.eng_misc_req;
    assign dbl_req   = |(bus.eng_misc_req & pending_q & ~gnt_d);

    // ---------------- Credits ----------------
    always_comb begin
        credit_d = credit_q;
        cred_ovf = 1'b0;
        if (gnt_any && !bus.tlx_afu_cmd_credit) begin
            credit_d = credit_q - CREDIT_W'(1);
        end else if (!gnt_any && bus.tlx_afu_cmd_credit) begin
            if (credit_q == '1) begin
                cred_ovf = 1'b1;
            end else begin
                credit_d = credit_q + CREDIT_W'(1);
            end
        end
    end

    // ---------------- Command capture ----------------
    // gnt_q is one-hot, so the AND-OR mux selects at most one lane; the
    // fields stay zero when nothing legal is presented.
    always_comb begin
        cap_sel   = bus.eng_cmd_valid & gnt_q;
        cmd_vld_d = |cap_sel;
        cmd_d     = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (cap_sel[i]) begin
                cmd_d.opcode = cmd_d.opcode | bus.eng_cmd_opcode[i*OPCODE_W +: OPCODE_W];
                cmd_d.actag  = cmd_d.actag  | bus.eng_cmd_actag[i*ACTAG_W +: ACTAG_W];
                cmd_d.afutag = cmd_d.afutag | bus.eng_cmd_afutag[i*AFUTAG_W +: AFUTAG_W];
                cmd_d.bdf    = cmd_d.bdf    | bus.eng_cmd_bdf[i*BDF_W +: BDF_W];
            end
        end
    end

    // Valid on an ungranted lane, or a granted lane staying silent.
    assign proto_err = (|(bus.eng_cmd_valid & ~gnt_q)) | (|(gnt_q & ~bus.eng_cmd_valid));

    // ---------------- Sticky errors ----------------
    always_comb begin
        err_d = err_q;
        if (dbl_req)   err_d[ERR_DBL_REQ]   = 1'b1;
        if (cred_ovf)  err_d[ERR_CRED_OVF]  = 1'b1;
        if (proto_err) err_d[ERR_CMD_PROTO] = 1'b1;
    end

    // ---------------- State ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            gnt_q     <= '0;
            credit_q  <= CRED_RST;
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
            err_q     <= '0;
        end else begin
            pending_q <= pending_d;
            gnt_q     <= gnt_d;
            credit_q  <= credit_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
        end
    end

    assign bus.arb_eng_misc_gnt   = gnt_q;
    assign bus.afu_tlx_cmd_valid  = cmd_vld_q;
    assign bus.afu_tlx_cmd_opcode = cmd_q.opcode;
    assign bus.afu_tlx_cmd_actag  = cmd_q.actag;
    assign bus.afu_tlx_cmd_afutag = cmd_q.afutag;
    assign bus.afu_tlx_cmd_bdf    = cmd_q.bdf;
    assign bus.arb_credit_cnt     = credit_q;
    assign bus.arb_misc_error     = err_q;

endmodule

// File: tb/tb_afp3_arb_misc_cmd.sv
// Bench for afp3_arb_misc_cmd: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_afp3_arb_misc_cmd;
    import afp3_arb_pkg::*;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int INIT = 8;
    localparam int CMAX = 15;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    afp3_arb_misc_cmd_if #(.NUM_ENG(N), .CREDIT_W(CW)) bus ();

    afp3_arb_misc_cmd #(.NUM_ENG(N), .CREDIT_W(CW), .INIT_CREDITS(INIT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks  = 0;
    int errors  = 0;
    int tv_seen = 0;

    // Stimulus
    logic [N-1:0]     req_i   = '0;
    logic [N-1:0]     vld_i   = '0;
    logic             ret_i   = 1'b0;
    logic [8*N-1:0]   op_flat = '0;
    logic [12*N-1:0]  at_flat = '0;
    logic [16*N-1:0]  ut_flat = '0;
    logic [16*N-1:0]  bd_flat = '0;

    assign bus.eng_misc_req       = req_i;
    assign bus.eng_cmd_valid      = vld_i;
    assign bus.tlx_afu_cmd_credit = ret_i;
    assign bus.eng_cmd_opcode     = op_flat;
    assign bus.eng_cmd_actag      = at_flat;
    assign bus.eng_cmd_afutag     = ut_flat;
    assign bus.eng_cmd_bdf        = bd_flat;

    // Reference model state: grant as lane number (-1 = none), credits as int
    logic [N-1:0] m_pend;
    int           m_last;
    int           m_gnt;
    int           m_cred;
    logic         m_tv;
    logic [7:0]   m_op;
    logic [11:0]  m_at;
    logic [15:0]  m_ut;
    logic [15:0]  m_bd;
    logic [2:0]   m_err;

    function automatic void model_reset();
        m_pend = '0;
        m_last = N - 1;
        m_gnt  = -1;
        m_cred = INIT;
        m_tv   = 1'b0;
        m_op   = '0;
        m_at   = '0;
        m_ut   = '0;
        m_bd   = '0;
        m_err  = '0;
    endfunction

    function automatic void model_step();
        int   gd;
        logic bad;
        gd = -1;
        if (m_cred > 0) begin
`ifdef AFP3_ARB_MISC_FIXED_PRI_EN
            for (int i = 0; i < N; i++)
                if (gd < 0 && m_pend[i]) gd = i;
`else
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (gd < 0 && m_pend[j]) gd = j;
            end
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && m_pend[i] && gd != i) m_err[0] = 1'b1;
            m_pend[i] = (m_pend[i] && gd != i) || req_i[i];
        end
        if (gd >= 0) m_last = gd;
        if (gd >= 0 && !ret_i) m_cred = m_cred - 1;
        else if (gd < 0 && ret_i) begin
            if (m_cred == CMAX) m_err[1] = 1'b1;
            else m_cred = m_cred + 1;
        end
        bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (vld_i[i] && i != m_gnt) bad = 1'b1;
        if (m_gnt >= 0 && !vld_i[m_gnt]) bad = 1'b1;
        if (bad) m_err[2] = 1'b1;
        m_tv = (m_gnt >= 0) && vld_i[m_gnt];
        if (m_tv) begin
            m_op = op_flat[8*m_gnt +: 8];
            m_at = at_flat[12*m_gnt +: 12];
            m_ut = ut_flat[16*m_gnt +: 16];
            m_bd = bd_flat[16*m_gnt +: 16];
        end else begin
            m_op = '0; m_at = '0; m_ut = '0; m_bd = '0;
        end
        m_gnt = gd;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] eg;
        eg = (m_gnt >= 0) ? (N'(1) << m_gnt) : '0;
        check("gnt",        32'(bus.arb_eng_misc_gnt),   32'(eg));
        check("tlx_valid",  32'(bus.afu_tlx_cmd_valid),  32'(m_tv));
        check("tlx_opcode", 32'(bus.afu_tlx_cmd_opcode), 32'(m_op));
        check("tlx_actag",  32'(bus.afu_tlx_cmd_actag),  32'(m_at));
        check("tlx_afutag", 32'(bus.afu_tlx_cmd_afutag), 32'(m_ut));
        check("tlx_bdf",    32'(bus.afu_tlx_cmd_bdf),    32'(m_bd));
        check("credit_cnt", 32'(bus.arb_credit_cnt),     32'(m_cred));
        check("error",      32'(bus.arb_misc_error),     32'(m_err));
        if (bus.afu_tlx_cmd_valid === 1'b1) tv_seen++;
    endtask

    // One clock: compare at the falling edge, then drive the next inputs.
    // The engine answers the grant the model says is showing this cycle.
    task automatic cycle(input logic [N-1:0] req, input logic ret,
                         input logic [N-1:0] extra, input logic drop);
        @(negedge clock);
        compare_all();
        req_i = req;
        ret_i = ret;
        vld_i = extra;
        if (m_gnt >= 0 && !drop) vld_i[m_gnt] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset_n = 1'b0;
        req_i = '0; ret_i = 1'b0; vld_i = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        tv_seen = 0;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            op_flat[8*i +: 8]   = 8'($urandom);
            at_flat[12*i +: 12] = 12'($urandom);
            ut_flat[16*i +: 16] = 16'($urandom);
            bd_flat[16*i +: 16] = 16'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            op_flat[8*i +: 8]   = 8'(8'h10 + i);
            at_flat[12*i +: 12] = 12'(12'h300 + i);
            ut_flat[16*i +: 16] = 16'(16'hA000 + i);
            bd_flat[16*i +: 16] = 16'(16'h0200 + i);
        end
        op_flat[8*2 +: 8]   = ASSIGN_ACTAG;
        at_flat[12*2 +: 12] = 12'h013;
        ut_flat[16*2 +: 16] = 16'hBEEF;
        bd_flat[16*2 +: 16] = 16'h0100;

        // Reset state
        repeat (2) @(negedge clock);
        compare_all();
        check("rst_gnt",    32'(bus.arb_eng_misc_gnt),  32'h0);
        check("rst_valid",  32'(bus.afu_tlx_cmd_valid), 32'h0);
        check("rst_credit", 32'(bus.arb_credit_cnt),    32'd8);
        check("rst_error",  32'(bus.arb_misc_error),    32'h0);
        reset_n = 1'b1;

        // Single request on lane 2
        cycle(4'b0100, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t1_gnt",    32'(bus.arb_eng_misc_gnt), 32'h4);
        check("t1_credit", 32'(bus.arb_credit_cnt),   32'd7);
        check("t1_model_credit", 32'(m_cred), 32'd7);
        cycle('0, 1'b0, '0, 1'b0);
        check("t1_valid",  32'(bus.afu_tlx_cmd_valid),  32'h1);
        check("t1_opcode", 32'(bus.afu_tlx_cmd_opcode), 32'h50);
        check("t1_actag",  32'(bus.afu_tlx_cmd_actag),  32'h013);
        check("t1_afutag", 32'(bus.afu_tlx_cmd_afutag), 32'hBEEF);
        check("t1_model_opcode", 32'(m_op), 32'h50);

        // All lanes at once -> 0,1,2,3 back to back
        do_reset();
        cycle(4'b1111, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        for (int k = 0; k < N; k++) begin
            cycle('0, 1'b0, '0, 1'b0);
            check("t2_rr_gnt", 32'(bus.arb_eng_misc_gnt), 32'(1) << k);
        end
        check("t2_credit", 32'(bus.arb_credit_cnt), 32'd4);
        cycle(4'b0010, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t2_regnt", 32'(bus.arb_eng_misc_gnt), 32'h2);
        check("t2_credit_after_regnt", 32'(bus.arb_credit_cnt), 32'd3);
        cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t2_credit_final", 32'(bus.arb_credit_cnt), 32'd4);

        // Credit exhaustion
        do_reset();
        cycle(4'b1111, 1'b0, '0, 1'b0);
        idle(6);
        cycle(4'b0111, 1'b0, '0, 1'b0);
        idle(6);
        check("t3_credit_one", 32'(bus.arb_credit_cnt), 32'd1);
        cycle(4'b0011, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t3_gnt_last_credit", 32'(bus.arb_eng_misc_gnt), 32'h1);
        check("t3_credit_zero",     32'(bus.arb_credit_cnt),   32'd0);
        repeat (4) begin
            cycle('0, 1'b0, '0, 1'b0);
            check("t3_blocked_gnt", 32'(bus.arb_eng_misc_gnt), 32'h0);
        end
        cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t3_credit_back", 32'(bus.arb_credit_cnt), 32'd1);
        cycle('0, 1'b0, '0, 1'b0);
        check("t3_waiter_gnt",    32'(bus.arb_eng_misc_gnt), 32'h2);
        check("t3_credit_end",    32'(bus.arb_credit_cnt),   32'd0);

        // Grant + return same cycle, then saturation
        repeat (3) cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t4_credit_three", 32'(bus.arb_credit_cnt), 32'd3);
        cycle(4'b0100, 1'b0, '0, 1'b0);
        cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t4_gnt",          32'(bus.arb_eng_misc_gnt), 32'h4);
        check("t4_credit_same",  32'(bus.arb_credit_cnt),   32'd3);
        repeat (12) cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t4_credit_full",  32'(bus.arb_credit_cnt), 32'd15);
        check("t4_no_err_yet",   32'(bus.arb_misc_error), 32'h0);
        cycle('0, 1'b1, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t4_credit_sat",   32'(bus.arb_credit_cnt), 32'd15);
        check("t4_ovf_err",      32'(bus.arb_misc_error), 32'h2);

        // Double request and stray cmd_valid
        do_reset();
        cycle(4'b0001, 1'b0, '0, 1'b0);
        idle(4);
        cycle(4'b0011, 1'b0, '0, 1'b0);
        cycle(4'b0001, 1'b0, '0, 1'b0);
        idle(6);
        cycle('0, 1'b0, 4'b1000, 1'b0);
        idle(3);
        check("t5_errors",   32'(bus.arb_misc_error), 32'h5);
        check("t5_tv_count", 32'(tv_seen),            32'd3);

        // Reset in the middle of a grant with a TLX command in flight
        do_reset();
        cycle(4'b0111, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        cycle('0, 1'b0, '0, 1'b0);
        check("t6_pre_gnt",   32'(bus.arb_eng_misc_gnt),  32'h2);
        check("t6_pre_valid", 32'(bus.afu_tlx_cmd_valid), 32'h1);
        #2 reset_n = 1'b0;
        req_i = '0; ret_i = 1'b0; vld_i = '0;
        #1;
        check("t6_rst_gnt",    32'(bus.arb_eng_misc_gnt),  32'h0);
        check("t6_rst_valid",  32'(bus.afu_tlx_cmd_valid), 32'h0);
        check("t6_rst_credit", 32'(bus.arb_credit_cnt),    32'd8);
        @(negedge clock);
        reset_n = 1'b1;
        idle(5);
        check("t6_quiet_gnt", 32'(bus.arb_eng_misc_gnt), 32'h0);
        check("t6_credit",    32'(bus.arb_credit_cnt),   32'd8);

        // Random traffic: sparse, dense, then with protocol faults
        for (int seg = 0; seg < 3; seg++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                logic [N-1:0] rq;
                logic [N-1:0] ex;
                logic         rt;
                logic         dr;
                rand_fields();
                for (int i = 0; i < N; i++)
                    rq[i] = (seg == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
                rt = ($urandom_range(0, 99) < 22);
                ex = '0;
                dr = 1'b0;
                if (seg == 2) begin
                    if ($urandom_range(0, 99) < 3) ex[$urandom_range(0, N-1)] = 1'b1;
                    dr = ($urandom_range(0, 99) < 3);
                end
                cycle(rq, rt, ex, dr);
            end
        end

        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
